serial_tx: RTL
==============

# serial_tx

Byte-wide 8N1 UART transmitter with an optional transmit FIFO. It is the console-output side of the serial link whose receive side drives the Galaksija keyboard matrix. It sits in the `clk` domain (25 MHz) next to the receiver. It serialises bytes handed to it by the CPU-side glue or a debug source onto `ser_tx`, using the same run-time `cfg_divider` bit period convention (clk cycles per bit) as the receiver.

## Interface
- `FIFO_AW`, default 4: log2 of FIFO depth (16 entries); used only with `SERIAL_TX_FIFO_EN`.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `cfg_divider`  in  32  clk cycles per bit; values < 2 treated as 2.
- `data`  in  8  byte to send.
- `valid`  in  1  `data` is offered this cycle.
- `ready`  out  1  block accepts `data` this cycle.
- `ser_tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress or bytes queued.
- `level`  out  FIFO_AW+1  bytes queued, not counting the frame on the wire.

## Operation
- Transfer: a byte is accepted on any rising edge where `valid && ready`. `data` must be held with `valid` until accepted.
- Frame format: start bit (0), data[0]..data[7] LSB first, one stop bit (1), 10 bit periods in total.
- FSM states:
  - IDLE: `ser_tx`=1. If the queue is non-empty, pop a byte into the shift register, latch the effective divider, and go to START.
  - START: hold 0 for one bit period, then go to DATA.
  - DATA: 8 bit periods with a 3-bit index. After index 7, go to STOP.
  - STOP: hold 1 for one bit period. Then, if the queue is non-empty, pop directly and go to START; otherwise go to IDLE.
- Bit timer: down-counter loaded with the effective divider minus 1. The bit ends when the counter reaches 0.
- Divider handling: the divider is latched once per frame, so a `cfg_divider` change mid-frame takes effect on the next frame.
- `ready` = queue not full. A push while full is impossible, since `ready`=0.
- Push and pop in the same cycle: both happen, and `level` is unchanged.
- `busy` = (state != IDLE) || (`level` != 0).
- `ser_tx`, `ready`, `busy` and `level` are all registered outputs.

## Timing
- Reset (`reset_n`=0 at an edge):
  - outputs: `ser_tx`=1, `busy`=0, `level`=0, `ready`=0 while reset is held, `ready`=1 on the first cycle after release;
  - internal: queue emptied, FSM to IDLE, timer cleared.
- Reset mid-frame aborts the frame. `ser_tx` returns high on the next edge. The partial byte is lost.
- Latency: byte accepted at edge N into an empty, idle block → `level`=1 after N, pop at N+1 with `ser_tx`=0 after edge N+1.
- Back-to-back bytes: the next start bit begins on the edge immediately after the last stop-bit cycle, with no idle gap.
- Frame length: exactly 10×divider clk cycles.
- Bit boundaries: every bit edge on `ser_tx` is aligned to a clk edge.
- `level` wraps only within 0..2^FIFO_AW. Pointers are FIFO_AW bits wide, and the count is FIFO_AW+1 bits.

## Configuration
- Macro: `SERIAL_TX_FIFO_EN`.
- Defined: queue is a 2^FIFO_AW-entry synchronous FIFO, and `level` ranges 0..2^FIFO_AW.
- Undefined: queue is a single holding register.
  - `ready` = holding register empty, and `level` is 0 or 1.
  - `FIFO_AW` is ignored.
  - The upper `level` bits are tied to 0.
- Serial timing is identical in both builds.

## Structure
- Shared package `serial_pkg` holds:
  - state encoding constants `S_IDLE`=0, `S_START`=1, `S_DATA`=2, `S_STOP`=3;
  - `MIN_DIVIDER`=2;
  - frame-length constant 10.
- The receiver uses the same package.
- Sub-module `serial_tx_fifo`: a generic synchronous FIFO with push/pop/full/empty/level. It is instantiated only under `SERIAL_TX_FIFO_EN`.

## Test plan
- `cfg_divider`=4, send 0x55 → `ser_tx` = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles, 40 cycles total; `busy` drops on the cycle after the stop bit.
- `cfg_divider`=217, push 0x41 then 0x0D back-to-back → two frames of 2170 cycles each with no idle cycle between; decoded bytes match.
- FIFO build, `FIFO_AW`=4, `valid` held high with 20 bytes → `ready`=0 once `level`=16. The stall persists until the first pop, and all 20 bytes are sent in order.
- Non-FIFO build, same stimulus → `ready` low while the holding register is full; order is preserved and no byte is dropped or duplicated.
- `cfg_divider`=0 and `cfg_divider`=1 → bits last 2 cycles. Changing the divider 4→8 mid-frame → the current frame stays at 4 and the next frame uses 8.
- Assert `reset_n`=0 during data bit 3 with 5 bytes queued → `ser_tx`=1, `level`=0, `busy`=0 after the edge. After release, a new byte 0xA5 is sent cleanly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial console link (transmitter and receiver).
package serial_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } serial_state_t;

   localparam int unsigned MIN_DIVIDER = 2;
   localparam int unsigned FRAME_BITS  = 10;
   localparam int unsigned DATA_BITS   = FRAME_BITS - 2;

   // Dividers below the minimum would make a bit shorter than the timer can count.
   function automatic logic [31:0] eff_divider(input logic [31:0] d);
      return (d < 32'(MIN_DIVIDER)) ? 32'(MIN_DIVIDER) : d;
   endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Generic synchronous FIFO used as the transmit queue.
// Only built when SERIAL_TX_FIFO_EN is defined.
`ifdef SERIAL_TX_FIFO_EN
module serial_tx_fifo #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign level    = count;

endmodule
`endif

// File: rtl/serial_tx.sv
// 8N1 UART transmitter; optional transmit FIFO enabled by SERIAL_TX_FIFO_EN,
// otherwise a single holding register queues one byte.
module serial_tx
   import serial_pkg::*;
#(
   parameter int FIFO_AW = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      cfg_divider,
   input  logic [7:0]       data,
   input  logic             valid,
   output logic             ready,
   output logic             ser_tx,
   output logic             busy,
   output logic [FIFO_AW:0] level
);

`ifdef SERIAL_TX_FIFO_EN
   localparam int unsigned QDEPTH = 1 << FIFO_AW;
`else
   localparam int unsigned QDEPTH = 1;
`endif
   localparam logic [FIFO_AW:0] QD   = (FIFO_AW+1)'(QDEPTH);
   localparam logic [2:0]       LAST = 3'(DATA_BITS - 1);

   logic             push;
   logic             pop;
   logic             q_full;
   logic             q_empty;
   logic [7:0]       q_data;
   logic [FIFO_AW:0] q_level;
   logic [FIFO_AW:0] q_level_nxt;

   assign push = valid && ready;

`ifdef SERIAL_TX_FIFO_EN
   serial_tx_fifo #(
      .AW (FIFO_AW),
      .DW (8)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (data),
      .pop       (pop),
      .pop_data  (q_data),
      .full      (q_full),
      .empty     (q_empty),
      .level     (q_level)
   );
`else
   logic       hold_valid;
   logic [7:0] hold_data;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (push) begin
         hold_valid <= 1'b1;
         hold_data  <= data;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end

   assign q_data  = hold_data;
   assign q_full  = hold_valid;
   assign q_empty = !hold_valid;
   assign q_level = {{FIFO_AW{1'b0}}, hold_valid};
`endif

   assign level = q_level;

   always_comb begin
      q_level_nxt = q_level;
      unique case ({push, pop})
         2'b10:   q_level_nxt = q_level + 1'b1;
         2'b01:   q_level_nxt = q_level - 1'b1;
         default: q_level_nxt = q_level;
      endcase
   end

   serial_state_t state;
   serial_state_t state_n;
   logic [7:0]    shreg;
   logic [7:0]    shreg_n;
   logic [2:0]    idx;
   logic [2:0]    idx_n;
   logic [31:0]   timer;
   logic [31:0]   timer_n;
   logic [31:0]   div_q;
   logic [31:0]   div_n;
   logic [31:0]   eff_div;
   logic          tdone;
   logic          load;

   assign eff_div = eff_divider(cfg_divider);
   assign tdone   = (timer == '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
         shreg <= '0;
         idx   <= '0;
         timer <= '0;
         div_q <= 32'(MIN_DIVIDER);
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         idx   <= idx_n;
         timer <= timer_n;
         div_q <= div_n;
      end
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      idx_n   = idx;
      timer_n = timer;
      div_n   = div_q;
      load    = 1'b0;
      unique case (state)
         S_IDLE: begin
            load = !q_empty;
         end
         S_START: begin
            timer_n = timer - 1'b1;
            if (tdone) begin
               state_n = S_DATA;
               idx_n   = '0;
               timer_n = div_q - 1'b1;
            end
         end
         S_DATA: begin
            timer_n = timer - 1'b1;
            if (tdone) begin
               timer_n = div_q - 1'b1;
               shreg_n = shreg >> 1;
               if (idx == LAST)
                  state_n = S_STOP;
               else
                  idx_n = idx + 1'b1;
            end
         end
         S_STOP: begin
            timer_n = timer - 1'b1;
            if (tdone) begin
               state_n = S_IDLE;
               load    = !q_empty;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // Divider is captured here so it stays fixed for the whole frame.
      if (load) begin
         state_n = S_START;
         shreg_n = q_data;
         div_n   = eff_div;
         timer_n = eff_div - 1'b1;
      end
      pop = load;
   end

   logic tx_d;
   logic busy_d;
   logic ready_d;

   always_comb begin
      tx_d = 1'b1;
      unique case (state_n)
         S_IDLE:  tx_d = 1'b1;
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shreg_n[0];
         S_STOP:  tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_n != S_IDLE) || (q_level_nxt != '0);
      // A push implies the queue is below full this cycle.
      if (push)
         ready_d = (q_level != QD - 1'b1) || pop;
      else
         ready_d = !q_full || pop;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ser_tx <= 1'b1;
         busy   <= 1'b0;
         ready  <= 1'b0;
      end else begin
         ser_tx <= tx_d;
         busy   <= busy_d;
         ready  <= ready_d;
      end
   end

endmodule
